usb_tx_arbiter: RTL

- Sequences the FT232H write path on usb_clock.
- Shares that path between two sources: the receiver's double-buffered IQ RAM (2 pages × 128 words × 48 bits) and the bandscope RAM (16384 × 16-bit).
- Reads the RAMs, frames the data into byte packets, and hands bytes to the USB write engine with a valid/ready handshake.
- IQ has priority; bandscope data is sent in preemptable 256-word chunks.

---
 rtl/usb_tx_arbiter_if.sv | 10 +
 rtl/usb_tx_arbiter.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/usb_tx_arbiter_if.sv
// Byte stream from the arbiter to the USB write engine.
// A byte moves on any clock where tx_valid && tx_ready.
interface usb_tx_arbiter_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/usb_tx_arbiter.sv
// FT232H write-path arbiter: frames IQ pages and bandscope chunks into byte packets,
// with IQ taking priority between packets.
module usb_tx_arbiter #(
  parameter logic [7:0] SYNC = 8'hA5,
  parameter logic [7:0] T_IQ = 8'h01,
  parameter logic [7:0] T_BS = 8'h02
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    iq_en,
  input  logic                    iq_page,
  output logic [7:0]              iq_rd_addr,
  input  logic [47:0]             iq_rd_data,
  input  logic                    bs_en,
  input  logic                    bs_ready,
  output logic [14:0]             bs_rd_addr,
  input  logic [15:0]             bs_rd_data,
  output logic                    bs_done,
  usb_tx_arbiter_if.master        tx,
  output logic [7:0]              iq_ovf_count,
  output logic                    busy
);

  localparam logic [3:0] S_IDLE  = 4'd0;
  localparam logic [3:0] S_H0    = 4'd1;
  localparam logic [3:0] S_H1    = 4'd2;
  localparam logic [3:0] S_H2    = 4'd3;
  localparam logic [3:0] S_ADDR  = 4'd4;
  localparam logic [3:0] S_WAIT  = 4'd5;
  localparam logic [3:0] S_SHIFT = 4'd6;
  localparam logic [3:0] S_DONE  = 4'd7;

  logic [3:0]  state;
  logic        pkt_iq;
  logic        pkt_page;
  logic [7:0]  word;
  logic [5:0]  chunk;
  logic [47:0] shreg;
  logic [2:0]  byte_cnt;
  logic        page_r;
  logic        page_d;
  logic        iq_pending;
  logic        iq_sel;
  logic [7:0]  ovf;
  logic        bs_arm;
  logic        bs_active;

  logic xfer;
  logic last_word;
  logic page_edge;
  logic iq_inflight;

  always_comb begin
    tx.tx_valid = (state == S_H0) || (state == S_H1) || (state == S_H2) || (state == S_SHIFT);
    tx.tx_data  = 8'h00;
    case (state)
      S_H0:    tx.tx_data = SYNC;
      S_H1:    tx.tx_data = pkt_iq ? T_IQ : T_BS;
      S_H2:    tx.tx_data = {2'b00, chunk};
      S_SHIFT: tx.tx_data = shreg[47:40];
      default: tx.tx_data = 8'h00;
    endcase
  end

  assign xfer         = tx.tx_valid && tx.tx_ready;
  assign last_word    = pkt_iq ? (word[6:0] == 7'h7f) : (word == 8'hff);
  assign page_edge    = page_r ^ page_d;
  assign iq_inflight  = pkt_iq && (state != S_IDLE);
  assign busy         = (state != S_IDLE) && (state != S_DONE);
  assign bs_done      = (state == S_DONE) && !pkt_iq && (chunk == 6'd63);
  assign iq_rd_addr   = {pkt_page, word[6:0]};
  assign bs_rd_addr   = {1'b0, chunk, word};
  assign iq_ovf_count = ovf;

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= S_IDLE;
      pkt_iq     <= 1'b0;
      pkt_page   <= 1'b0;
      word       <= 8'd0;
      chunk      <= 6'd0;
      shreg      <= 48'd0;
      byte_cnt   <= 3'd0;
      page_r     <= 1'b0;
      page_d     <= 1'b0;
      iq_pending <= 1'b0;
      iq_sel     <= 1'b0;
      ovf        <= 8'd0;
      bs_arm     <= 1'b0;
      bs_active  <= 1'b0;
    end else begin
      page_r <= iq_page;
      page_d <= page_r;

      case (state)
        S_IDLE: begin
          if (iq_pending) begin
            state      <= S_H0;
            pkt_iq     <= 1'b1;
            pkt_page   <= iq_sel;
            iq_pending <= 1'b0;
            word       <= 8'd0;
          end else if (bs_active) begin
            state  <= S_H0;
            pkt_iq <= 1'b0;
            word   <= 8'd0;
          end
        end
        S_H0:    if (xfer) state <= S_H1;
        S_H1:    if (xfer) state <= pkt_iq ? S_ADDR : S_H2;
        S_H2:    if (xfer) state <= S_ADDR;
        S_ADDR:  state <= S_WAIT;
        S_WAIT: begin
          shreg    <= pkt_iq ? iq_rd_data : {bs_rd_data, 32'd0};
          byte_cnt <= pkt_iq ? 3'd5 : 3'd1;
          state    <= S_SHIFT;
        end
        S_SHIFT: begin
          if (xfer) begin
            if (byte_cnt == 3'd0) begin
              if (last_word) begin
                state <= S_DONE;
              end else begin
                word  <= word + 8'd1;
                state <= S_ADDR;
              end
            end else begin
              shreg    <= shreg << 8;
              byte_cnt <= byte_cnt - 3'd1;
            end
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          if (!pkt_iq) begin
            if (chunk == 6'd63) bs_active <= 1'b0;
            else                chunk     <= chunk + 6'd1;
          end
        end
        default: state <= S_IDLE;
      endcase

      // Placed after the FSM so a new edge wins over the clear on H0 entry.
      if (!iq_en) begin
        iq_pending <= 1'b0;
      end else if (page_edge) begin
        iq_pending <= 1'b1;
        iq_sel     <= ~page_r;
        if ((iq_pending || iq_inflight) && (ovf != 8'hff)) ovf <= ovf + 8'd1;
      end

      if (!bs_en && (state == S_IDLE)) bs_active <= 1'b0;
      if (!bs_ready) begin
        bs_arm <= 1'b1;
      end else if (bs_en && bs_arm) begin
        bs_active <= 1'b1;
        chunk     <= 6'd0;
        bs_arm    <= 1'b0;
      end
    end
  end

endmodule
